// File: rtl/pool_pkg.sv
// Shared types and helpers for the pool2d 2x2/stride-2 pooling stage.
package pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  localparam int DATA_W_DEF = 32;

  // Widest sample the max helper accepts; callers sign-extend into it.
  localparam int MAX2_W = 64;

  function automatic logic signed [MAX2_W-1:0] pool_max2(
    input logic signed [MAX2_W-1:0] a,
    input logic signed [MAX2_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool2d_linebuf.sv
// Half-width line buffer holding per-channel pair results from the even row.
module pool2d_linebuf #(
  parameter int CHANNELS = 4,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 14,
  parameter int AW       = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W:0]   wr_data [CHANNELS],
  output logic [DATA_W:0]   rd_data [CHANNELS]
);

  logic [DATA_W:0] mem [DEPTH][CHANNELS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        mem[addr][c] <= wr_data[c];
      end
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      rd_data[c] = mem[addr][c];
    end
  end

endmodule

// File: rtl/pool2d.sv
// Streaming 2x2/stride-2 max/avg pooling over raster pixels, all channels in parallel.
// Define POOL2D_RELU_EN to clamp negative pooled values to zero at the output.
module pool2d
  import pool_pkg::*;
#(
  parameter int         CHANNELS = 4,
  parameter int         DATA_W   = DATA_W_DEF,
  parameter int         IMG_W    = 28,
  parameter int         IMG_H    = 28,
  parameter pool_mode_e MODE     = POOL_MAX
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     input_valid,
  input  logic                     sof,
  input  logic signed [DATA_W-1:0] d_in [CHANNELS],
  output logic                     output_valid,
  output logic                     o_sof,
  output logic                     o_eof,
  output logic signed [DATA_W-1:0] d_out [CHANNELS]
);

  localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB_DEPTH = (IMG_W >= 2) ? IMG_W / 2 : 1;
  localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  if (IMG_W < 2 || (IMG_W % 2) != 0) begin : g_bad_img_w
    $error("pool2d: IMG_W must be even and >= 2");
  end
  if (IMG_H < 2 || (IMG_H % 2) != 0) begin : g_bad_img_h
    $error("pool2d: IMG_H must be even and >= 2");
  end
  if (DATA_W > MAX2_W) begin : g_bad_data_w
    $error("pool2d: DATA_W exceeds pool_max2 width");
  end

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] eff_col;
  logic [RW-1:0] eff_row;
  logic [AW-1:0] lb_addr;
  logic          lb_we;
  logic          win_done;

  logic signed [DATA_W-1:0] hold     [CHANNELS];
  logic signed [DATA_W-1:0] pair_max [CHANNELS];
  logic signed [DATA_W-1:0] quad_max [CHANNELS];
  logic signed [DATA_W:0]   pair_sum [CHANNELS];
  logic signed [DATA_W+1:0] quad_sum [CHANNELS];
  logic signed [DATA_W-1:0] pooled   [CHANNELS];
  logic [DATA_W:0]          lb_wr    [CHANNELS];
  logic [DATA_W:0]          lb_rd    [CHANNELS];

  // A qualified sof restarts at pixel 0; the hold register and line buffer are
  // both rewritten before being read again, so no explicit flush is needed.
  always_comb begin
    eff_col  = (input_valid && sof) ? '0 : col;
    eff_row  = (input_valid && sof) ? '0 : row;
    lb_addr  = AW'(eff_col >> 1);
    lb_we    = input_valid && !eff_row[0] && eff_col[0];
    win_done = input_valid && eff_row[0] && eff_col[0];
  end

  pool2d_linebuf #(
    .CHANNELS (CHANNELS),
    .DATA_W   (DATA_W),
    .DEPTH    (LB_DEPTH),
    .AW       (AW)
  ) u_linebuf (
    .clk     (clk),
    .we      (lb_we),
    .addr    (lb_addr),
    .wr_data (lb_wr),
    .rd_data (lb_rd)
  );

  // The line buffer entry is DATA_W+1 wide: the pair sum in AVG mode, the
  // sign-extended pair max in MAX mode.
  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      pair_max[c] = DATA_W'(pool_max2(MAX2_W'(hold[c]), MAX2_W'(d_in[c])));
      pair_sum[c] = (DATA_W+1)'(hold[c]) + (DATA_W+1)'(d_in[c]);
      quad_max[c] = DATA_W'(pool_max2(MAX2_W'(pair_max[c]),
                                      MAX2_W'($signed(lb_rd[c][DATA_W-1:0]))));
      quad_sum[c] = (DATA_W+2)'(pair_sum[c]) + (DATA_W+2)'($signed(lb_rd[c]));
      if (MODE == POOL_AVG) begin
        lb_wr[c]  = pair_sum[c];
        pooled[c] = quad_sum[c][DATA_W+1:2];
      end else begin
        lb_wr[c]  = (DATA_W+1)'(pair_max[c]);
        pooled[c] = quad_max[c];
      end
`ifdef POOL2D_RELU_EN
      if (pooled[c][DATA_W-1]) begin
        pooled[c] = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col          <= '0;
      row          <= '0;
      output_valid <= 1'b0;
      o_sof        <= 1'b0;
      o_eof        <= 1'b0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        hold[c]  <= '0;
        d_out[c] <= '0;
      end
    end else begin
      output_valid <= 1'b0;
      o_sof        <= 1'b0;
      o_eof        <= 1'b0;
      if (input_valid) begin
        if (eff_col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= (eff_row == RW'(IMG_H - 1)) ? '0 : eff_row + RW'(1);
        end else begin
          col <= eff_col + CW'(1);
          row <= eff_row;
        end
        if (!eff_col[0]) begin
          for (int unsigned c = 0; c < CHANNELS; c++) begin
            hold[c] <= d_in[c];
          end
        end
      end
      if (win_done) begin
        output_valid <= 1'b1;
        o_sof        <= (eff_row == RW'(1)) && (eff_col == CW'(1));
        o_eof        <= (eff_row == RW'(IMG_H - 1)) && (eff_col == CW'(IMG_W - 1));
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          d_out[c] <= pooled[c];
        end
      end
    end
  end

endmodule

// File: tb/tb_pool2d.sv
// Bench for pool2d: MAX and AVG instances fed the same stream, checked against a frame-array model.
module tb_pool2d;
  import pool_pkg::*;

  localparam int CH = 2;
  localparam int DW = 32;
  localparam int W  = 4;
  localparam int H  = 4;

  typedef logic [CH-1:0][DW-1:0] pix_t;
  typedef struct packed {
    int unsigned cyc;
    logic [1:0]  vld;
    logic [1:0]  sof;
    logic [1:0]  eof;
    pix_t        mx;
    pix_t        av;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic input_valid = 1'b0;
  logic sof = 1'b0;
  logic signed [DW-1:0] d_in [CH];
  logic max_valid, max_sof, max_eof, avg_valid, avg_sof, avg_eof;
  logic signed [DW-1:0] max_dout [CH];
  logic signed [DW-1:0] avg_dout [CH];

  pool2d #(.CHANNELS(CH), .DATA_W(DW), .IMG_W(W), .IMG_H(H), .MODE(POOL_MAX)) dut_max (
    .clk(clk), .rst(rst), .input_valid(input_valid), .sof(sof), .d_in(d_in),
    .output_valid(max_valid), .o_sof(max_sof), .o_eof(max_eof), .d_out(max_dout));

  pool2d #(.CHANNELS(CH), .DATA_W(DW), .IMG_W(W), .IMG_H(H), .MODE(POOL_AVG)) dut_avg (
    .clk(clk), .rst(rst), .input_valid(input_valid), .sof(sof), .d_in(d_in),
    .output_valid(avg_valid), .o_sof(avg_sof), .o_eof(avg_eof), .d_out(avg_dout));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   vecs;
  int   fails;
  rec_t exp_q[$];
  rec_t act_q[$];
  rec_t mon_r;
  pix_t frame [H][W];
  pix_t stim  [H*W];
  int   mr, mc;

  always @(negedge clk) begin
    if (max_valid === 1'b1 || avg_valid === 1'b1) begin
      mon_r.cyc = cyc;
      mon_r.vld = {max_valid, avg_valid};
      mon_r.sof = {max_sof, avg_sof};
      mon_r.eof = {max_eof, avg_eof};
      for (int c = 0; c < CH; c++) begin
        mon_r.mx[c] = max_dout[c];
        mon_r.av[c] = avg_dout[c];
      end
      act_q.push_back(mon_r);
    end
  end

  task automatic drive_beat(input bit v, input bit s, input pix_t data, input bit r);
    rec_t   e;
    longint a, sum, mx;
    @(negedge clk);
    rst = r;
    input_valid = v;
    sof = s;
    for (int c = 0; c < CH; c++) d_in[c] = data[c];
    if (r) begin
      mr = 0;
      mc = 0;
    end else if (v) begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      frame[mr][mc] = data;
      if (mr % 2 == 1 && mc % 2 == 1) begin
        e.cyc = cyc + 1;
        e.vld = 2'b11;
        e.sof = (mr == 1 && mc == 1) ? 2'b11 : 2'b00;
        e.eof = (mr == H-1 && mc == W-1) ? 2'b11 : 2'b00;
        for (int c = 0; c < CH; c++) begin
          sum = 0;
          mx  = longint'($signed(frame[mr-1][mc-1][c]));
          for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
              a = longint'($signed(frame[mr-1+dr][mc-1+dc][c]));
              sum += a;
              if (a > mx) mx = a;
            end
          end
          sum = sum >>> 2;
`ifdef POOL2D_RELU_EN
          if (mx < 0) mx = 0;
          if (sum < 0) sum = 0;
`endif
          e.mx[c] = DW'(mx);
          e.av[c] = DW'(sum);
        end
        exp_q.push_back(e);
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr = (mr + 1) % H;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit with_sof, input int unsigned gap_pct, input int unsigned n_beats);
    for (int unsigned i = 0; i < n_beats; i++) begin
      while ($urandom_range(99) < gap_pct)
        drive_beat(1'b0, 1'($urandom_range(1)), pix_t'({$urandom, $urandom}), 1'b0);
      drive_beat(1'b1, with_sof && (i == 0), stim[i], 1'b0);
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive_beat(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic fill_ramp();
    for (int unsigned i = 0; i < H*W; i++) begin
      stim[i][0] = DW'(i);
      stim[i][1] = $urandom;
    end
  endtask

  task automatic fill_random();
    for (int unsigned i = 0; i < H*W; i++) stim[i] = pix_t'({$urandom, $urandom});
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) drive_beat(1'b0, 1'b0, '0, 1'b1);
    vecs++;
    if ({max_valid, max_sof, max_eof, avg_valid, avg_sof, avg_eof} !== 6'b0) begin
      fails++;
      $display("FAIL reset flags: got %b, expected 000000",
               {max_valid, max_sof, max_eof, avg_valid, avg_sof, avg_eof});
    end
    for (int c = 0; c < CH; c++) begin
      vecs++;
      if (max_dout[c] !== '0 || avg_dout[c] !== '0) begin
        fails++;
        $display("FAIL reset d_out[%0d]: got max=%h avg=%h, expected 0", c, max_dout[c], avg_dout[c]);
      end
    end
  endtask

  task automatic test_ramp();
    int unsigned mx_tab [4] = '{5, 7, 13, 15};
    int unsigned av_tab [4] = '{2, 4, 10, 12};
    exp_q.delete(); act_q.delete();
    fill_ramp();
    send_frame(1'b1, 0, H*W);
    idle(2);
    vecs++;
    if (act_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL ramp count: got %0d outputs, expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      vecs++;
      if (act_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL ramp out%0d: got cyc=%0d vld=%b sof=%b eof=%b max=%h avg=%h, expected cyc=%0d vld=%b sof=%b eof=%b max=%h avg=%h",
                 i, act_q[i].cyc, act_q[i].vld, act_q[i].sof, act_q[i].eof, act_q[i].mx, act_q[i].av,
                 exp_q[i].cyc, exp_q[i].vld, exp_q[i].sof, exp_q[i].eof, exp_q[i].mx, exp_q[i].av);
      end
    end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (i >= act_q.size()) begin
        fails++;
        $display("FAIL ramp table%0d: got no output, expected max=%0d avg=%0d", i, mx_tab[i], av_tab[i]);
      end else if (act_q[i].mx[0] !== DW'(mx_tab[i]) || act_q[i].av[0] !== DW'(av_tab[i]) ||
                   act_q[i].sof !== ((i == 0) ? 2'b11 : 2'b00) || act_q[i].eof !== ((i == 3) ? 2'b11 : 2'b00)) begin
        fails++;
        $display("FAIL ramp table%0d: got max=%0d avg=%0d sof=%b eof=%b, expected max=%0d avg=%0d",
                 i, act_q[i].mx[0], act_q[i].av[0], act_q[i].sof, act_q[i].eof, mx_tab[i], av_tab[i]);
      end
    end
  endtask

  task automatic test_negative();
    logic signed [DW-1:0] neg_exp, avg_exp;
`ifdef POOL2D_RELU_EN
    neg_exp = '0;
    avg_exp = '0;
`else
    neg_exp = -3;
    avg_exp = -2;
`endif
    exp_q.delete(); act_q.delete();
    for (int unsigned i = 0; i < H*W; i++) begin
      stim[i][0] = DW'(-3);
      stim[i][1] = DW'(-3);
    end
    stim[0][1] = DW'(-1);
    stim[1][1] = DW'(-2);
    stim[4][1] = DW'(-2);
    stim[5][1] = DW'(-2);
    send_frame(1'b1, 0, H*W);
    idle(2);
    vecs++;
    if (act_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL negative count: got %0d outputs, expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      vecs++;
      if (act_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL negative out%0d: got cyc=%0d vld=%b sof=%b eof=%b max=%h avg=%h, expected cyc=%0d vld=%b sof=%b eof=%b max=%h avg=%h",
                 i, act_q[i].cyc, act_q[i].vld, act_q[i].sof, act_q[i].eof, act_q[i].mx, act_q[i].av,
                 exp_q[i].cyc, exp_q[i].vld, exp_q[i].sof, exp_q[i].eof, exp_q[i].mx, exp_q[i].av);
      end
      vecs++;
      if (act_q[i].mx[0] !== neg_exp || act_q[i].av[0] !== neg_exp) begin
        fails++;
        $display("FAIL negative const%0d: got max=%0d avg=%0d, expected %0d",
                 i, $signed(act_q[i].mx[0]), $signed(act_q[i].av[0]), neg_exp);
      end
    end
    vecs++;
    if (act_q.size() == 0 || act_q[0].av[1] !== avg_exp) begin
      fails++;
      $display("FAIL avg_floor: got %0d, expected %0d", (act_q.size() == 0) ? 0 : $signed(act_q[0].av[1]), avg_exp);
    end
  endtask

  task automatic test_gaps();
    exp_q.delete(); act_q.delete();
    fill_ramp();
    send_frame(1'b1, 50, H*W);
    idle(3);
    vecs++;
    if (act_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL gaps count: got %0d outputs, expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      vecs++;
      if (act_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL gaps out%0d: got cyc=%0d vld=%b sof=%b eof=%b max=%h avg=%h, expected cyc=%0d vld=%b sof=%b eof=%b max=%h avg=%h",
                 i, act_q[i].cyc, act_q[i].vld, act_q[i].sof, act_q[i].eof, act_q[i].mx, act_q[i].av,
                 exp_q[i].cyc, exp_q[i].vld, exp_q[i].sof, exp_q[i].eof, exp_q[i].mx, exp_q[i].av);
      end
    end
    vecs++;
    if (max_dout[0] !== exp_q[$].mx[0] || avg_dout[0] !== exp_q[$].av[0]) begin
      fails++;
      $display("FAIL gaps hold: got max=%0d avg=%0d, expected max=%0d avg=%0d",
               max_dout[0], avg_dout[0], exp_q[$].mx[0], exp_q[$].av[0]);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.delete(); act_q.delete();
    fill_random();
    send_frame(1'b1, 0, H*W);
    fill_random();
    send_frame(1'b0, 30, H*W);
    idle(2);
    vecs++;
    if (act_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL b2b count: got %0d outputs, expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      vecs++;
      if (act_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL b2b out%0d: got cyc=%0d vld=%b sof=%b eof=%b max=%h avg=%h, expected cyc=%0d vld=%b sof=%b eof=%b max=%h avg=%h",
                 i, act_q[i].cyc, act_q[i].vld, act_q[i].sof, act_q[i].eof, act_q[i].mx, act_q[i].av,
                 exp_q[i].cyc, exp_q[i].vld, exp_q[i].sof, exp_q[i].eof, exp_q[i].mx, exp_q[i].av);
      end
    end
  endtask

  task automatic test_sof_restart();
    exp_q.delete(); act_q.delete();
    fill_ramp();
    send_frame(1'b1, 0, 9);
    fill_random();
    send_frame(1'b1, 0, H*W);
    idle(2);
    vecs++;
    if (act_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL restart count: got %0d outputs, expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      vecs++;
      if (act_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL restart out%0d: got cyc=%0d vld=%b sof=%b eof=%b max=%h avg=%h, expected cyc=%0d vld=%b sof=%b eof=%b max=%h avg=%h",
                 i, act_q[i].cyc, act_q[i].vld, act_q[i].sof, act_q[i].eof, act_q[i].mx, act_q[i].av,
                 exp_q[i].cyc, exp_q[i].vld, exp_q[i].sof, exp_q[i].eof, exp_q[i].mx, exp_q[i].av);
      end
    end
  endtask

  task automatic test_reset_midframe();
    exp_q.delete(); act_q.delete();
    fill_ramp();
    send_frame(1'b1, 0, 13);
    drive_beat(1'b1, 1'b0, stim[13], 1'b1);
    vecs++;
    if ({max_valid, max_sof, max_eof, avg_valid, avg_sof, avg_eof} !== 6'b0 ||
        max_dout[0] !== '0 || avg_dout[0] !== '0) begin
      fails++;
      $display("FAIL midreset state: got flags=%b max=%0d avg=%0d, expected flags=000000 max=0 avg=0",
               {max_valid, max_sof, max_eof, avg_valid, avg_sof, avg_eof}, max_dout[0], avg_dout[0]);
    end
    idle(1);
    fill_random();
    send_frame(1'b1, 20, H*W);
    idle(2);
    vecs++;
    if (act_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL midreset count: got %0d outputs, expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      vecs++;
      if (act_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL midreset out%0d: got cyc=%0d vld=%b sof=%b eof=%b max=%h avg=%h, expected cyc=%0d vld=%b sof=%b eof=%b max=%h avg=%h",
                 i, act_q[i].cyc, act_q[i].vld, act_q[i].sof, act_q[i].eof, act_q[i].mx, act_q[i].av,
                 exp_q[i].cyc, exp_q[i].vld, exp_q[i].sof, exp_q[i].eof, exp_q[i].mx, exp_q[i].av);
      end
    end
  endtask

  task automatic test_random();
    exp_q.delete(); act_q.delete();
    for (int f = 0; f < 3; f++) begin
      fill_random();
      send_frame(f == 0, 25, H*W);
    end
    idle(2);
    vecs++;
    if (act_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL random count: got %0d outputs, expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      vecs++;
      if (act_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL random out%0d: got cyc=%0d vld=%b sof=%b eof=%b max=%h avg=%h, expected cyc=%0d vld=%b sof=%b eof=%b max=%h avg=%h",
                 i, act_q[i].cyc, act_q[i].vld, act_q[i].sof, act_q[i].eof, act_q[i].mx, act_q[i].av,
                 exp_q[i].cyc, exp_q[i].vld, exp_q[i].sof, exp_q[i].eof, exp_q[i].mx, exp_q[i].av);
      end
    end
  endtask

  initial begin
    vecs  = 0;
    fails = 0;
    mr    = 0;
    mc    = 0;
    for (int c = 0; c < CH; c++) d_in[c] = '0;
    test_reset();
    test_ramp();
    test_negative();
    test_gaps();
    test_back_to_back();
    test_sof_restart();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/pool2d.md
# pool2d

Parametrised 2×2/stride-2 pooling stage for the streaming CNN pipeline, generalising the fixed max- and average-pooling stages into one block. Selected by parameter, it performs either max or average reduction. It accepts one raster-ordered pixel per valid beat with all channels in parallel, and emits one pooled pixel per completed window. It sits between convolution layers (or before the fully-connected stage) and uses the same `sof`/`input_valid` → `o_sof`/`output_valid` streaming handshake, plus an end-of-frame marker.

## Interface
- `CHANNELS`, 4: parallel channels per beat.
- `DATA_W`, 32: signed two's-complement sample width.
- `IMG_W`, 28: input frame width in pixels. Must be even and ≥2; elaboration error otherwise.
- `IMG_H`, 28: input frame height in pixels. Must be even and ≥2; elaboration error otherwise.
- `MODE`, POOL_MAX: `pool_pkg::pool_mode_e`; either POOL_MAX or POOL_AVG.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `input_valid` in 1: `d_in` beat valid. Gaps are allowed anywhere.
- `sof` in 1: first pixel of frame; qualified by `input_valid`.
- `d_in` in [CHANNELS] × DATA_W: unpacked array, one sample per channel.
- `output_valid` out 1: `d_out` valid for one cycle.
- `o_sof` out 1: first pooled pixel of frame; coincides with `output_valid`.
- `o_eof` out 1: last pooled pixel of frame; coincides with `output_valid`.
- `d_out` out [CHANNELS] × DATA_W: pooled samples.

## Operation
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance only on `input_valid`.
  - `col` wraps to 0 and increments `row`.
  - `row` wraps to 0 after IMG_H-1, so back-to-back frames work without `sof`.
- `input_valid & sof` forces the beat to be treated as row 0, col 0. It discards all partial window state and any held pixel. Line-buffer contents are overwritten before use.
- Even row:
  - Even col: hold the pixel in a per-channel register.
  - Odd col: combine the held pixel with the current pixel and write the result to line-buffer entry `col>>1` (IMG_W/2 entries × CHANNELS).
- Odd row:
  - Even col: hold the pixel.
  - Odd col: combine the held pixel, the current pixel and line-buffer entry `col>>1`. Register the result to `d_out`.
- Combine rule, POOL_MAX: signed maximum.
- Combine rule, POOL_AVG:
  - Sums are DATA_W+2 bits wide; the line buffer stores the DATA_W+1-bit pair sum.
  - Output is the 4-sample sum arithmetic-shifted right by 2 (floor toward −∞), truncated to DATA_W. The truncation is lossless.
- `o_sof` is asserted on the output from row 1, col 1.
- `o_eof` is asserted on the output from row IMG_H-1, col IMG_W-1.
- `sof` on a beat with `input_valid` low is ignored.

## Timing
- Reset values: `output_valid`, `o_sof` and `o_eof` are 0; `d_out` is all-zero. `col`, `row` and the held registers are cleared. Line-buffer contents are don't-care.
- Latency: 1 cycle. Outputs are registered the cycle after the beat that completes the window (odd row, odd col).
- Throughput: one input per cycle sustained, with no backpressure. Output is one pulse per four inputs, at most one every other cycle.
- `output_valid` is high for exactly one cycle per window. `d_out` holds its value until the next output.
- `rst` mid-frame: on the next edge the block is fully in reset state and any in-flight output is dropped. The next frame must begin with `sof` or arrive aligned to pixel 0.
- `sof` on the window-completing beat of the previous frame cannot occur (col 0 ≠ odd col). `sof` always aborts and restarts.

## Configuration
- `POOL2D_RELU_EN` defined: a fused ReLU is applied at the output register, so any negative pooled value is emitted as 0. This applies to both modes.
- Not defined: the pooled value is emitted unmodified, including negatives.

## Structure
- `pool_pkg`:
  - `pool_mode_e` (POOL_MAX, POOL_AVG);
  - `DATA_W_DEF` = 32;
  - helper function `pool_max2(a, b)` (signed).
- Sub-module `pool2d_linebuf`:
  - IMG_W/2-deep × CHANNELS × (DATA_W+1) storage;
  - one write port and one read port, same address, combinational read;
  - no reset on the array.
- Top `pool2d` contains the counters, hold registers, combine datapath and output register.

## Test plan
- MAX, 4×4, 1 channel, pixels 0..15 raster, `sof` on pixel 0 → outputs 5, 7, 13, 15.
  - `o_sof` on 5, `o_eof` on 15.
  - Each output 1 cycle after pixels 5, 7, 13, 15.
- AVG, same stimulus → outputs 2, 4, 10, 12. AVG window {-1, -2, -2, -2} → -2 (floor of -7/4).
- `POOL2D_RELU_EN`, MAX, all pixels negative (−3) → all outputs 0. Without the macro → all outputs −3.
- Random `input_valid` gaps (about 50% duty) on the 4×4 ramp → identical output values, order and `o_sof`/`o_eof` markers.
- Two frames back-to-back with no `sof` on the second → the second frame produces correct outputs. `sof` asserted at row 2 col 1 of a frame → partial state is discarded and the restarted frame's outputs are correct.
- `rst` pulsed during row 3 → the output of the interrupted window is never emitted, outputs return to reset values, and the following `sof` frame is correct.
